// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Tracks in-flight load/MDU destinations and stalls dependent IDs.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int RF_AWIDTH = 5,
    parameter int NUM_PEND  = 4,
    parameter int LOAD_LAT  = 1,
    parameter int MDU_LAT   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [RF_AWIDTH-1:0] id_rs1,
    input  logic [RF_AWIDTH-1:0] id_rs2,
    input  logic                 id_rs1_used,
    input  logic                 id_rs2_used,
    input  logic [RF_AWIDTH-1:0] id_rd,
    input  logic [1:0]           id_kind,
    input  logic                 branch_taken,
    input  logic                 jump_taken,
    input  logic                 flush_all,
    output logic                 data_stall,
    output logic                 ctrl_flush,
    output logic [3:0]           pend_cnt,
    output logic [31:0]          stall_cycles
);

    localparam logic [3:0]     c_LOAD_CNT = 4'(LOAD_LAT);
    localparam logic [3:0]     c_MDU_CNT  = 4'(MDU_LAT);
    localparam logic [1:0]     c_KIND_LOAD = 2'd1;
    localparam logic [1:0]     c_KIND_MDU  = 2'd2;
    localparam logic [3:0]     c_NUM_PEND  = 4'(NUM_PEND);

    logic [NUM_PEND-1:0]  r_valid;
    logic [RF_AWIDTH-1:0] r_rd  [NUM_PEND];
    logic [3:0]           r_cnt [NUM_PEND];
    logic [31:0]          r_stall_cycles;

    logic                 w_writes_late;
    logic                 w_match_rs1;
    logic                 w_match_rs2;
    logic                 w_match_rd;
    logic                 w_hit_rs1;
    logic                 w_hit_rs2;
    logic                 w_waw;
    logic                 w_full_stall;
    logic                 w_data_stall;
    logic                 w_issue;
    logic                 w_alloc;
    logic                 w_free_found;
    logic [NUM_PEND-1:0]  w_alloc_oh;
    logic [3:0]           w_pend_cnt;

    // Only loads and MDU ops with a real destination ever occupy an entry.
    assign w_writes_late = ((id_kind == c_KIND_LOAD) || (id_kind == c_KIND_MDU))
                           && (id_rd != '0);

    always_comb begin
        w_match_rs1  = 1'b0;
        w_match_rs2  = 1'b0;
        w_match_rd   = 1'b0;
        w_free_found = 1'b0;
        w_alloc_oh   = '0;
        w_pend_cnt   = 4'd0;
        for (int i = 0; i < NUM_PEND; i++) begin
            if (r_valid[i]) begin
                if (r_rd[i] == id_rs1) w_match_rs1 = 1'b1;
                if (r_rd[i] == id_rs2) w_match_rs2 = 1'b1;
                if (r_rd[i] == id_rd)  w_match_rd  = 1'b1;
                w_pend_cnt = w_pend_cnt + 4'd1;
            end else if (!w_free_found) begin
                w_alloc_oh[i] = 1'b1;
                w_free_found  = 1'b1;
            end
        end
    end

    assign ctrl_flush   = branch_taken | jump_taken;
    assign w_hit_rs1    = id_rs1_used && (id_rs1 != '0) && w_match_rs1;
    assign w_hit_rs2    = id_rs2_used && (id_rs2 != '0) && w_match_rs2;
    assign w_waw        = w_writes_late && w_match_rd;
    // Occupancy is the registered count; an entry retiring this cycle does not help.
    assign w_full_stall = w_writes_late && (w_pend_cnt == c_NUM_PEND);
    assign w_data_stall = id_valid && !ctrl_flush && !flush_all
                          && (w_hit_rs1 || w_hit_rs2 || w_waw || w_full_stall);
    assign w_issue      = id_valid && !w_data_stall && !ctrl_flush && !flush_all;
    assign w_alloc      = w_issue && w_writes_late && w_free_found;

    assign data_stall   = w_data_stall;
    assign pend_cnt     = w_pend_cnt;
    assign stall_cycles = r_stall_cycles;

    generate
        for (genvar g = 0; g < NUM_PEND; g++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid[g] <= 1'b0;
                    r_rd[g]    <= '0;
                    r_cnt[g]   <= 4'd0;
                end else if (flush_all) begin
                    r_valid[g] <= 1'b0;
                    r_cnt[g]   <= 4'd0;
                end else if (w_alloc && w_alloc_oh[g]) begin
                    r_valid[g] <= 1'b1;
                    r_rd[g]    <= id_rd;
                    r_cnt[g]   <= (id_kind == c_KIND_LOAD) ? c_LOAD_CNT : c_MDU_CNT;
                end else if (r_valid[g]) begin
                    if (r_cnt[g] == 4'd1) begin
                        r_valid[g] <= 1'b0;
                    end
                    r_cnt[g] <= r_cnt[g] - 4'd1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= 32'd0;
        end else if (w_data_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Directed self-checking bench for hazard_scoreboard (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  id_rd;
    logic [1:0]  id_kind;
    logic        branch_taken;
    logic        jump_taken;
    logic        flush_all;
    logic        data_stall;
    logic        ctrl_flush;
    logic [3:0]  pend_cnt;
    logic [31:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    hazard_scoreboard #(
        .RF_AWIDTH(5),
        .NUM_PEND (4),
        .LOAD_LAT (1),
        .MDU_LAT  (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rd       (id_rd),
        .id_kind     (id_kind),
        .branch_taken(branch_taken),
        .jump_taken  (jump_taken),
        .flush_all   (flush_all),
        .data_stall  (data_stall),
        .ctrl_flush  (ctrl_flush),
        .pend_cnt    (pend_cnt),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic [1:0] kind);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs1_used = u1;
        id_rs2      = rs2;
        id_rs2_used = u2;
        id_rd       = rd;
        id_kind     = kind;
    endtask

    initial begin
        rst_n        = 1'b0;
        branch_taken = 1'b0;
        jump_taken   = 1'b0;
        flush_all    = 1'b0;
        set_id(1, 5, 1, 0, 0, 8, 0);
        branch_taken = 1'b1;
        #3;
        chk("rst_data_stall", 32'(data_stall), 0);
        chk("rst_pend_cnt", 32'(pend_cnt), 0);
        chk("rst_stall_cycles", stall_cycles, 0);
        chk("rst_ctrl_flush_on", 32'(ctrl_flush), 1);
        branch_taken = 1'b0;
        jump_taken   = 1'b1;
        #1;
        chk("rst_ctrl_flush_jump", 32'(ctrl_flush), 1);
        jump_taken = 1'b0;
        #1;
        chk("rst_ctrl_flush_off", 32'(ctrl_flush), 0);
        tick();
        tick();
        rst_n = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0);

        // Load-use: exactly one bubble
        tick();
        set_id(1, 0, 0, 0, 0, 5, 1);
        #1 chk("lu_load_issue", 32'(data_stall), 0);
        tick();
        set_id(1, 5, 1, 0, 0, 8, 0);
        #1 chk("lu_stall", 32'(data_stall), 1);
        chk("lu_pend1", 32'(pend_cnt), 1);
        tick();
        #1 chk("lu_issue", 32'(data_stall), 0);
        chk("lu_pend0", 32'(pend_cnt), 0);
        chk("lu_stall_cycles", stall_cycles, 1);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0);

        // MDU-use on rs2: 8 stall cycles, none when rs2 unused
        tick();
        set_id(1, 0, 0, 0, 0, 7, 2);
        #1 chk("mdu_div_issue", 32'(data_stall), 0);
        tick();
        set_id(1, 0, 0, 7, 0, 0, 0);
        #1 chk("mdu_rs2_unused", 32'(data_stall), 0);
        id_rs2_used = 1'b1;
        #1 chk("mdu_stall_c1", 32'(data_stall), 1);
        for (int k = 2; k <= 8; k++) begin
            tick();
            #1 chk($sformatf("mdu_stall_c%0d", k), 32'(data_stall), 1);
        end
        tick();
        #1 chk("mdu_release", 32'(data_stall), 0);
        chk("mdu_stall_cycles", stall_cycles, 9);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0);

        // Table full: divs to x1..x4 then x6
        for (int i = 1; i <= 4; i++) begin
            tick();
            set_id(1, 0, 0, 0, 0, 5'(i), 2);
            #1 chk($sformatf("full_div%0d_issue", i), 32'(data_stall), 0);
        end
        tick();
        set_id(1, 0, 0, 0, 0, 6, 2);
        #1 chk("full_stall_c4", 32'(data_stall), 1);
        chk("full_pend_c4", 32'(pend_cnt), 4);
        for (int k = 5; k <= 8; k++) begin
            tick();
            #1 chk($sformatf("full_stall_c%0d", k), 32'(data_stall), 1);
            chk($sformatf("full_pend_c%0d", k), 32'(pend_cnt), 4);
        end
        tick();
        #1 chk("full_issue_c9", 32'(data_stall), 0);
        chk("full_pend_c9", 32'(pend_cnt), 3);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0);
        #1 chk("full_pend_c10", 32'(pend_cnt), 3);
        for (int k = 0; k < 8; k++) tick();
        #1 chk("full_drain", 32'(pend_cnt), 0);
        chk("full_stall_cycles", stall_cycles, 14);

        // Control flush keeps entries; flush_all clears and blocks allocation
        tick();
        set_id(1, 0, 0, 0, 0, 9, 2);
        tick();
        set_id(1, 0, 0, 0, 0, 5, 1);
        #1 chk("cf_load_issue", 32'(data_stall), 0);
        tick();
        set_id(1, 5, 1, 0, 0, 8, 0);
        branch_taken = 1'b1;
        #1 chk("cf_ctrl_flush", 32'(ctrl_flush), 1);
        chk("cf_no_stall", 32'(data_stall), 0);
        chk("cf_pend_kept", 32'(pend_cnt), 2);
        tick();
        branch_taken = 1'b0;
        flush_all    = 1'b1;
        set_id(1, 0, 0, 0, 0, 10, 2);
        #1 chk("fa_no_stall", 32'(data_stall), 0);
        chk("fa_pend_before", 32'(pend_cnt), 1);
        tick();
        flush_all = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        #1 chk("fa_pend_cleared", 32'(pend_cnt), 0);
        chk("fa_stall_cycles", stall_cycles, 14);

        // x0 destination and x0 reader
        tick();
        set_id(1, 0, 0, 0, 0, 0, 1);
        #1 chk("x0_load_issue", 32'(data_stall), 0);
        tick();
        set_id(1, 0, 1, 0, 1, 3, 0);
        #1 chk("x0_reader_no_stall", 32'(data_stall), 0);
        chk("x0_no_alloc", 32'(pend_cnt), 0);

        // Asynchronous reset with three entries pending
        tick();
        set_id(1, 0, 0, 0, 0, 11, 2);
        tick();
        set_id(1, 0, 0, 0, 0, 12, 2);
        tick();
        set_id(1, 0, 0, 0, 0, 13, 2);
        tick();
        set_id(1, 11, 1, 0, 0, 14, 0);
        #1 chk("ar_stall_before", 32'(data_stall), 1);
        chk("ar_pend_before", 32'(pend_cnt), 3);
        rst_n = 1'b0;
        #1 chk("ar_pend_async", 32'(pend_cnt), 0);
        chk("ar_stall_async", 32'(data_stall), 0);
        chk("ar_stall_cycles", stall_cycles, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1 chk("ar_post_no_stall", 32'(data_stall), 0);
        chk("ar_post_pend", 32'(pend_cnt), 0);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0);
        #1 chk("ar_post_issue_pend", 32'(pend_cnt), 0);
        chk("ar_post_stall_cycles", stall_cycles, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
